// File: rtl/wb_load_align_unit_if.sv
// Writeback request and second-word memory bus for wb_load_align_unit.
// master = pipeline/memory side, slave = the align unit.
interface wb_load_align_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic             in_is_load;
    logic [2:0]       in_funct3;
    logic [WIDTH-1:0] in_addr;
    logic [WIDTH-1:0] in_rdata;
    logic [WIDTH-1:0] in_value;
    logic [4:0]       in_rd;
    logic             in_load_regfile;
    logic             mem_read_o;
    logic [WIDTH-1:0] mem_addr_o;
    logic             mem_resp_i;
    logic [WIDTH-1:0] mem_rdata_i;

    modport master (
        output in_valid, in_is_load, in_funct3, in_addr, in_rdata, in_value, in_rd,
        output in_load_regfile, mem_resp_i, mem_rdata_i,
        input  in_ready, mem_read_o, mem_addr_o
    );

    modport slave (
        input  in_valid, in_is_load, in_funct3, in_addr, in_rdata, in_value, in_rd,
        input  in_load_regfile, mem_resp_i, mem_rdata_i,
        output in_ready, mem_read_o, mem_addr_o
    );
endinterface

// File: rtl/wb_load_align_unit.sv
// Writeback regfile mux with load extraction/extension; loads that straddle a
// data word are completed with a second read and a two-word merge.
module wb_load_align_unit #(
    parameter int unsigned WIDTH       = 32,
    parameter bit          MISALIGN_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    wb_load_align_unit_if.slave bus,
    output logic                load_regfile_o,
    output logic [4:0]          rd_o,
    output logic [WIDTH-1:0]    regfile_wdata_o,
    output logic                misalign_err_o
);
    localparam int unsigned BYTES = WIDTH / 8;
    localparam int unsigned OFFW  = $clog2(BYTES);

    typedef enum logic {StIdle, StFetch2} state_e;

    state_e           state_q, state_d;
    logic             wen_q, wen_d;
    logic             err_q, err_d;
    logic [4:0]       rd_q, rd_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [4:0]       lat_rd_q, lat_rd_d;
    logic             lat_wen_q, lat_wen_d;
    logic [2:0]       lat_f3_q, lat_f3_d;
    logic [OFFW-1:0]  lat_off_q, lat_off_d;
    logic [WIDTH-1:0] lat_rdata_q, lat_rdata_d;
    logic [WIDTH-1:0] maddr_q, maddr_d;

    logic                  accept;
    logic [OFFW-1:0]       off;
    logic [4:0]            span;
    logic                  straddle;
    logic                  illegal;
    logic                  req_wen;
    logic [WIDTH-OFFW-1:0] next_hi;

    // Shift the (up to two) words down by the byte offset, keep N bytes, extend.
    function automatic logic [WIDTH-1:0] extract(input logic [2*WIDTH-1:0] dw,
                                                 input logic [OFFW-1:0]    o,
                                                 input logic [2:0]         f3);
        logic [63:0] s;
        logic [63:0] r;
        logic        sx;
        s  = 64'(dw >> {o, 3'b000});
        sx = 1'b0;
        r  = s;
        case (f3[1:0])
            2'd0: begin sx = ~f3[2] & s[7];  r = {{56{sx}}, s[7:0]};  end
            2'd1: begin sx = ~f3[2] & s[15]; r = {{48{sx}}, s[15:0]}; end
            2'd2: begin sx = ~f3[2] & s[31]; r = {{32{sx}}, s[31:0]}; end
            default: r = s;
        endcase
        return WIDTH'(r);
    endfunction

    always_comb begin
        accept   = bus.in_valid && (state_q == StIdle);
        off      = bus.in_addr[OFFW-1:0];
        span     = 5'(off) + (5'd1 << bus.in_funct3[1:0]);
        straddle = span > 5'(BYTES);
        illegal  = (bus.in_funct3 == 3'b111) ||
                   ((WIDTH == 32) && ((bus.in_funct3 == 3'b011) || (bus.in_funct3 == 3'b110)));
        req_wen  = bus.in_load_regfile && (bus.in_rd != 5'd0);
        next_hi  = bus.in_addr[WIDTH-1:OFFW] + (WIDTH-OFFW)'(1);
    end

    always_comb begin
        state_d     = state_q;
        wen_d       = 1'b0;
        err_d       = 1'b0;
        rd_d        = rd_q;
        wdata_d     = wdata_q;
        lat_rd_d    = lat_rd_q;
        lat_wen_d   = lat_wen_q;
        lat_f3_d    = lat_f3_q;
        lat_off_d   = lat_off_q;
        lat_rdata_d = lat_rdata_q;
        maddr_d     = maddr_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (!bus.in_is_load) begin
                        wen_d   = req_wen;
                        rd_d    = bus.in_rd;
                        wdata_d = bus.in_value;
                    end else if (illegal || (straddle && !MISALIGN_EN)) begin
                        err_d   = 1'b1;
                        rd_d    = bus.in_rd;
                        wdata_d = '0;
                    end else if (straddle) begin
                        lat_rd_d    = bus.in_rd;
                        lat_wen_d   = req_wen;
                        lat_f3_d    = bus.in_funct3;
                        lat_off_d   = off;
                        lat_rdata_d = bus.in_rdata;
                        maddr_d     = {next_hi, {OFFW{1'b0}}};
                        state_d     = StFetch2;
                    end else begin
                        wen_d   = req_wen;
                        rd_d    = bus.in_rd;
                        wdata_d = extract({{WIDTH{1'b0}}, bus.in_rdata}, off, bus.in_funct3);
                    end
                end
            end
            StFetch2: begin
                if (bus.mem_resp_i) begin
                    wen_d   = lat_wen_q;
                    rd_d    = lat_rd_q;
                    wdata_d = extract({bus.mem_rdata_i, lat_rdata_q}, lat_off_q, lat_f3_q);
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            wen_q       <= 1'b0;
            err_q       <= 1'b0;
            rd_q        <= '0;
            wdata_q     <= '0;
            lat_rd_q    <= '0;
            lat_wen_q   <= 1'b0;
            lat_f3_q    <= '0;
            lat_off_q   <= '0;
            lat_rdata_q <= '0;
            maddr_q     <= '0;
        end else begin
            state_q     <= state_d;
            wen_q       <= wen_d;
            err_q       <= err_d;
            rd_q        <= rd_d;
            wdata_q     <= wdata_d;
            lat_rd_q    <= lat_rd_d;
            lat_wen_q   <= lat_wen_d;
            lat_f3_q    <= lat_f3_d;
            lat_off_q   <= lat_off_d;
            lat_rdata_q <= lat_rdata_d;
            maddr_q     <= maddr_d;
        end
    end

    assign bus.in_ready    = (state_q == StIdle);
    assign bus.mem_read_o  = (state_q == StFetch2);
    assign bus.mem_addr_o  = maddr_q;
    assign load_regfile_o  = wen_q;
    assign misalign_err_o  = err_q;
    assign rd_o            = rd_q;
    assign regfile_wdata_o = wdata_q;
endmodule

// File: tb/tb_wb_load_align_unit.sv
// Bench for wb_load_align_unit: three instances (32b split, 64b split, 32b error
// mode) checked against an arithmetic byte-extraction model.
module tb_wb_load_align_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int          sel;
    logic        s_valid, s_is_load, s_lrf, s_resp;
    logic [2:0]  s_f3;
    logic [4:0]  s_rd;
    logic [63:0] s_addr, s_rdata, s_value, s_mrdata;

    int n_chk = 0;
    int n_pass = 0;

    wb_load_align_unit_if #(.WIDTH(32)) if_a ();
    wb_load_align_unit_if #(.WIDTH(64)) if_b ();
    wb_load_align_unit_if #(.WIDTH(32)) if_c ();

    assign if_a.in_valid = s_valid && (sel == 0);
    assign if_b.in_valid = s_valid && (sel == 1);
    assign if_c.in_valid = s_valid && (sel == 2);
    assign if_a.mem_resp_i = s_resp && (sel == 0);
    assign if_b.mem_resp_i = s_resp && (sel == 1);
    assign if_c.mem_resp_i = s_resp && (sel == 2);
    assign if_a.in_is_load = s_is_load;
    assign if_b.in_is_load = s_is_load;
    assign if_c.in_is_load = s_is_load;
    assign if_a.in_funct3 = s_f3;
    assign if_b.in_funct3 = s_f3;
    assign if_c.in_funct3 = s_f3;
    assign if_a.in_addr = s_addr[31:0];
    assign if_b.in_addr = s_addr;
    assign if_c.in_addr = s_addr[31:0];
    assign if_a.in_rdata = s_rdata[31:0];
    assign if_b.in_rdata = s_rdata;
    assign if_c.in_rdata = s_rdata[31:0];
    assign if_a.in_value = s_value[31:0];
    assign if_b.in_value = s_value;
    assign if_c.in_value = s_value[31:0];
    assign if_a.in_rd = s_rd;
    assign if_b.in_rd = s_rd;
    assign if_c.in_rd = s_rd;
    assign if_a.in_load_regfile = s_lrf;
    assign if_b.in_load_regfile = s_lrf;
    assign if_c.in_load_regfile = s_lrf;
    assign if_a.mem_rdata_i = s_mrdata[31:0];
    assign if_b.mem_rdata_i = s_mrdata;
    assign if_c.mem_rdata_i = s_mrdata[31:0];

    logic        lrf_a, lrf_b, lrf_c, err_a, err_b, err_c;
    logic [4:0]  rd_a, rd_b, rd_c;
    logic [31:0] wd_a, wd_c;
    logic [63:0] wd_b;

    wb_load_align_unit #(.WIDTH(32), .MISALIGN_EN(1'b1)) u_a (
        .clk(clk), .rst(rst), .bus(if_a), .load_regfile_o(lrf_a), .rd_o(rd_a),
        .regfile_wdata_o(wd_a), .misalign_err_o(err_a)
    );
    wb_load_align_unit #(.WIDTH(64), .MISALIGN_EN(1'b1)) u_b (
        .clk(clk), .rst(rst), .bus(if_b), .load_regfile_o(lrf_b), .rd_o(rd_b),
        .regfile_wdata_o(wd_b), .misalign_err_o(err_b)
    );
    wb_load_align_unit #(.WIDTH(32), .MISALIGN_EN(1'b0)) u_c (
        .clk(clk), .rst(rst), .bus(if_c), .load_regfile_o(lrf_c), .rd_o(rd_c),
        .regfile_wdata_o(wd_c), .misalign_err_o(err_c)
    );

    logic        o_ready, o_mread, o_lrf, o_err;
    logic [4:0]  o_rd;
    logic [63:0] o_maddr, o_wdata;

    always_comb begin
        o_ready = 1'b0; o_mread = 1'b0; o_lrf = 1'b0; o_err = 1'b0;
        o_rd = '0; o_maddr = '0; o_wdata = '0;
        case (sel)
            0: begin
                o_ready = if_a.in_ready; o_mread = if_a.mem_read_o; o_maddr = 64'(if_a.mem_addr_o);
                o_lrf = lrf_a; o_err = err_a; o_rd = rd_a; o_wdata = 64'(wd_a);
            end
            1: begin
                o_ready = if_b.in_ready; o_mread = if_b.mem_read_o; o_maddr = if_b.mem_addr_o;
                o_lrf = lrf_b; o_err = err_b; o_rd = rd_b; o_wdata = wd_b;
            end
            default: begin
                o_ready = if_c.in_ready; o_mread = if_c.mem_read_o; o_maddr = 64'(if_c.mem_addr_o);
                o_lrf = lrf_c; o_err = err_c; o_rd = rd_c; o_wdata = 64'(wd_c);
            end
        endcase
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference: bytes of {second, first} word starting at the offset, N of them.
    function automatic logic [63:0] ref_data(input int w, input logic [2:0] f3,
                                             input logic [63:0] addr, input logic [63:0] rdata,
                                             input logic [63:0] mrdata);
        logic [127:0] wmask, cat, m, v;
        int nbytes, off, n;
        nbytes = w / 8;
        off    = int'(addr % 64'(nbytes));
        n      = 1 << f3[1:0];
        wmask  = (128'd1 << w) - 128'd1;
        cat    = ((128'(mrdata) & wmask) << w) | (128'(rdata) & wmask);
        m      = (128'd1 << (8 * n)) - 128'd1;
        v      = (cat >> (8 * off)) & m;
        if (!f3[2] && v[8*n-1]) v = v | ~m;
        return 64'(v & wmask);
    endfunction

    task automatic txn(input int k, input bit ld, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] rdata, input logic [63:0] value, input logic [4:0] rd,
                       input bit lrf, input int dly, input logic [63:0] mrdata);
        int w, nbytes, off, n;
        bit me, illegal, strad, err, wen, split;
        logic [127:0] wmask, a;
        logic [63:0] exp_addr, exp_data;
        w      = (k == 1) ? 64 : 32;
        me     = (k != 2);
        nbytes = w / 8;
        wmask  = (128'd1 << w) - 128'd1;
        a      = 128'(addr) & wmask;
        off    = int'(a % 128'(nbytes));
        n      = 1 << f3[1:0];
        illegal = (f3 == 3'd7) || (w == 32 && (f3 == 3'd3 || f3 == 3'd6));
        strad  = (off + n) > nbytes;
        err    = ld && (illegal || (strad && !me));
        split  = ld && !illegal && strad && me;
        wen    = lrf && (rd != 5'd0) && !err;
        exp_addr = 64'((((a / 128'(nbytes)) + 128'd1) * 128'(nbytes)) & wmask);
        exp_data = ld ? ref_data(w, f3, addr, rdata, split ? mrdata : 64'd0)
                      : 64'(128'(value) & wmask);

        sel = k; s_is_load = ld; s_f3 = f3; s_addr = addr; s_rdata = rdata; s_value = value;
        s_rd = rd; s_lrf = lrf; s_mrdata = mrdata; s_resp = 1'b0;
        #0;
        check("ready_before", 64'(o_ready), 64'd1);
        s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        if (split) begin
            check("split_mread", 64'(o_mread), 64'd1);
            check("split_maddr", o_maddr, exp_addr);
            check("split_ready", 64'(o_ready), 64'd0);
            check("split_nowr", 64'(o_lrf), 64'd0);
            for (int i = 0; i < dly; i++) begin
                @(posedge clk); #1;
                check("split_hold", 64'(o_mread), 64'd1);
            end
            s_resp = 1'b1;
            @(posedge clk); #1;
            s_resp = 1'b0;
            check("split_mread_off", 64'(o_mread), 64'd0);
            check("split_ready_back", 64'(o_ready), 64'd1);
        end
        check("wen", 64'(o_lrf), 64'(wen));
        check("err", 64'(o_err), 64'(err));
        if (wen) begin
            check("rd", 64'(o_rd), 64'(rd));
            check("wdata", o_wdata, exp_data);
        end
        if (err && !illegal) check("err_wdata", o_wdata, 64'd0);
        @(posedge clk); #1;
        check("wen_pulse", 64'(o_lrf), 64'd0);
        check("err_pulse", 64'(o_err), 64'd0);
    endtask

    initial begin
        sel = 0; s_valid = 0; s_is_load = 0; s_lrf = 0; s_resp = 0; s_f3 = '0; s_rd = '0;
        s_addr = '0; s_rdata = '0; s_value = '0; s_mrdata = '0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sel = k; #1;
            check("rst_ready", 64'(o_ready), 64'd1);
            check("rst_mread", 64'(o_mread), 64'd0);
            check("rst_maddr", o_maddr, 64'd0);
            check("rst_wen", 64'(o_lrf), 64'd0);
            check("rst_err", 64'(o_err), 64'd0);
            check("rst_rd", 64'(o_rd), 64'd0);
            check("rst_wdata", o_wdata, 64'd0);
        end
        @(posedge clk); #1;

        txn(0, 0, 3'b000, 64'h0, 64'h0, 64'hDEADBEEF, 5'd5, 1, 0, 64'h0);
        txn(0, 1, 3'b000, 64'h1003, 64'h80FFFF7F, 64'h0, 5'd6, 1, 0, 64'h0);
        txn(0, 1, 3'b100, 64'h1003, 64'h80FFFF7F, 64'h0, 5'd7, 1, 0, 64'h0);
        txn(0, 1, 3'b010, 64'h1002, 64'hAABBCCDD, 64'h0, 5'd8, 1, 3, 64'h11223344);
        txn(1, 1, 3'b101, 64'h7, 64'h9A00_0000_0000_0000, 64'h0, 5'd9, 1, 1, 64'h12);
        txn(1, 1, 3'b011, 64'h10, 64'h8877665544332211, 64'h0, 5'd10, 1, 0, 64'h0);
        txn(0, 1, 3'b010, 64'hFFFF_FFFE, 64'h01020304, 64'h0, 5'd11, 1, 0, 64'h0A0B0C0D);
        txn(2, 1, 3'b001, 64'h3, 64'h12345678, 64'h0, 5'd12, 1, 0, 64'h0);
        txn(0, 0, 3'b000, 64'h0, 64'h0, 64'h55AA55AA, 5'd0, 1, 0, 64'h0);
        txn(0, 1, 3'b011, 64'h0, 64'h11111111, 64'h0, 5'd13, 1, 0, 64'h0);

        // Reset while waiting for the second word, then a stray response.
        sel = 0; s_is_load = 1; s_f3 = 3'b010; s_addr = 64'h2003; s_rdata = 64'h1;
        s_rd = 5'd14; s_lrf = 1; s_valid = 1;
        @(posedge clk); #1;
        s_valid = 0;
        check("rst_f2_mread_pre", 64'(o_mread), 64'd1);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        check("rst_f2_mread", 64'(o_mread), 64'd0);
        check("rst_f2_ready", 64'(o_ready), 64'd1);
        check("rst_f2_wen", 64'(o_lrf), 64'd0);
        s_resp = 1; s_mrdata = 64'hFFFFFFFF;
        @(posedge clk); #1;
        s_resp = 0;
        check("late_resp_wen", 64'(o_lrf), 64'd0);
        check("late_resp_mread", 64'(o_mread), 64'd0);

        for (int t = 0; t < 200; t++) begin
            txn($urandom_range(0, 2), $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                5'($urandom_range(0, 31)), $urandom_range(0, 4) != 0, $urandom_range(0, 3),
                {$urandom, $urandom});
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
